debug_unit: RTL

//  UART-side controller sitting directly upstream of the pipeline top. Assembles program

---
 rtl/debug_unit_pkg.sv | 29 ++
 rtl/debug_unit_tx_serializer.sv | 66 ++++++
 rtl/debug_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_unit_pkg.sv
// Shared definitions for the UART debug unit: command codes, FSM states, report sizing.
// Optional feature macro: DEBUG_CYCLE_COUNT_EN (appends a 32-bit enable-cycle count to the report).
package debug_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP      = 3'd4,
    ST_SEND      = 3'd5,
    ST_SEND_WAIT = 3'd6
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_EXIT = 8'h45;

  localparam int CYC_CNT_W = 32;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int CYC_CNT_BYTES = 4;
`else
  localparam int CYC_CNT_BYTES = 0;
`endif
  localparam int REPORT_BYTES = 8 + CYC_CNT_BYTES;

endpackage

// File: rtl/debug_unit_tx_serializer.sv
// Report serializer: captures a snapshot and emits it MSB-first, one byte per tx_start,
// advancing on tx_done and stopping (no wrap) at the last byte.
module debug_tx_serializer #(
  parameter int BYTE_SZ = 8,
  parameter int N_BYTES = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_load,
  input  logic [N_BYTES*BYTE_SZ-1:0] i_snapshot,
  input  logic                       i_start,
  input  logic                       i_tx_done,
  output logic [BYTE_SZ-1:0]         o_tx_data,
  output logic                       o_tx_start,
  output logic                       o_busy,
  output logic                       o_last
);

  localparam int SNAP_W = N_BYTES * BYTE_SZ;
  localparam int CNT_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [SNAP_W-1:0]  shift_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic [BYTE_SZ-1:0] tx_data_r;
  logic               tx_start_r;

  assign o_last     = (cnt_r == CNT_W'(N_BYTES - 1));
  assign o_busy     = busy_r;
  assign o_tx_data  = tx_data_r;
  assign o_tx_start = tx_start_r;

  // Snapshot shift register and byte counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_r <= {SNAP_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else if (i_load) begin
      shift_r <= i_snapshot;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b1;
    end else if (i_tx_done && busy_r) begin
      if (o_last) begin
        busy_r <= 1'b0;
      end else begin
        shift_r <= {shift_r[SNAP_W-BYTE_SZ-1:0], {BYTE_SZ{1'b0}}};
        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Registered byte output and one-cycle start pulse
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_data_r  <= {BYTE_SZ{1'b0}};
      tx_start_r <= 1'b0;
    end else begin
      tx_start_r <= i_start;
      if (i_start) begin
        tx_data_r <= shift_r[SNAP_W-1 -: BYTE_SZ];
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// UART debug controller: loads program words, gates pipeline enable (run/step) and sends
// PC + data reports. Optional DEBUG_CYCLE_COUNT_EN adds an enable-cycle counter to the report.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int                 INST_SZ   = 32,
  parameter int                 PC_SZ     = 32,
  parameter int                 BYTE_SZ   = 8,
  parameter logic [INST_SZ-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [INST_SZ-1:0] i_data,
  input  logic               i_halt,
  output logic               o_write,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_enable,
  output logic [BYTE_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [2:0]         o_state
);

  localparam int WORD_BYTES = INST_SZ / BYTE_SZ;
  localparam int BCNT_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int RPT_BYTES  = (PC_SZ + INST_SZ) / BYTE_SZ + CYC_CNT_BYTES;
  localparam int SNAP_W     = RPT_BYTES * BYTE_SZ;

  state_e              state_r, state_s;
  logic [BCNT_W-1:0]   byte_cnt_r;
  logic [INST_SZ-1:0]  word_r, instr_r, word_next_s;
  logic                write_r, enable_r;
  logic                step_mode_r, step_pend_r, send_first_r;
  logic                word_clr_s, word_shift_s, enable_s, step_go_s;
  logic                step_set_s, step_clr_s, cyc_clr_s;
  logic                ser_load_s, ser_start_s, ser_tx_done_s, ser_busy_s, ser_last_s;
  logic [SNAP_W-1:0]   snapshot_s;

  assign word_next_s   = {word_r[INST_SZ-BYTE_SZ-1:0], i_rx_data};
  assign ser_tx_done_s = (state_r == ST_SEND_WAIT) && i_tx_done && ser_busy_s;
  assign o_write       = write_r;
  assign o_instruction = instr_r;
  assign o_enable      = enable_r;
  assign o_state       = state_r;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and control strobes
  always_comb begin
    state_s      = state_r;
    word_clr_s   = 1'b0;
    word_shift_s = 1'b0;
    step_go_s    = 1'b0;
    step_set_s   = 1'b0;
    step_clr_s   = 1'b0;
    cyc_clr_s    = 1'b0;
    ser_load_s   = 1'b0;
    ser_start_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_s    = ST_LOAD;
              word_clr_s = 1'b1;
            end
            CMD_RUN: begin
              state_s    = i_halt ? ST_SEND : ST_RUN;
              cyc_clr_s  = 1'b1;
              step_clr_s = 1'b1;
            end
            CMD_STEP: begin
              state_s    = ST_STEP;
              cyc_clr_s  = 1'b1;
              step_set_s = 1'b1;
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_rx_done) begin
          word_shift_s = 1'b1;
          state_s      = (byte_cnt_r == BCNT_W'(WORD_BYTES - 1)) ? ST_WRITE : ST_LOAD;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        state_s = (instr_r == HALT_WORD) ? ST_IDLE : ST_LOAD;
      end
      ST_RUN: begin
        state_s = i_halt ? ST_SEND : ST_RUN;
      end
      ST_STEP: begin
        // A step enables for the one cycle flagged by step_pend_r, then reports
        if (step_pend_r) begin
          state_s = ST_SEND;
        end else if (i_rx_done) begin
          case (i_rx_data)
            CMD_NEXT: begin
              if (i_halt) begin
                state_s = ST_SEND;
              end else begin
                step_go_s = 1'b1;
              end
            end
            CMD_EXIT: begin
              state_s    = ST_IDLE;
              step_clr_s = 1'b1;
            end
            default: state_s = ST_STEP;
          endcase
        end else begin
          state_s = ST_STEP;
        end
      end
      ST_SEND: begin
        // First SEND cycle captures the snapshot; later visits launch the current byte
        if (send_first_r) begin
          ser_load_s = 1'b1;
        end else begin
          ser_start_s = 1'b1;
          state_s     = ST_SEND_WAIT;
        end
      end
      ST_SEND_WAIT: begin
        if (ser_tx_done_s) begin
          if (ser_last_s) begin
            state_s = step_mode_r ? ST_STEP : ST_IDLE;
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_SEND_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    enable_s = (state_s == ST_RUN) || step_go_s;
  end

  // Program word assembly, MSB-first
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_cnt_r <= {BCNT_W{1'b0}};
      word_r     <= {INST_SZ{1'b0}};
      instr_r    <= {INST_SZ{1'b0}};
    end else if (word_clr_s) begin
      byte_cnt_r <= {BCNT_W{1'b0}};
      word_r     <= {INST_SZ{1'b0}};
    end else if (word_shift_s) begin
      word_r <= word_next_s;
      if (byte_cnt_r == BCNT_W'(WORD_BYTES - 1)) begin
        byte_cnt_r <= {BCNT_W{1'b0}};
        instr_r    <= word_next_s;
      end else begin
        byte_cnt_r <= byte_cnt_r + {{(BCNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Mode flags and registered pipeline controls
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      step_mode_r  <= 1'b0;
      step_pend_r  <= 1'b0;
      send_first_r <= 1'b0;
      write_r      <= 1'b0;
      enable_r     <= 1'b0;
    end else begin
      if (step_set_s) begin
        step_mode_r <= 1'b1;
      end else if (step_clr_s) begin
        step_mode_r <= 1'b0;
      end
      step_pend_r  <= step_go_s;
      send_first_r <= (state_s == ST_SEND) && (state_r != ST_SEND) && (state_r != ST_SEND_WAIT);
      write_r      <= (state_s == ST_WRITE);
      enable_r     <= enable_s;
    end
  end

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [CYC_CNT_W-1:0] cyc_cnt_r;

  // Saturating count of enabled cycles
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cyc_cnt_r <= {CYC_CNT_W{1'b0}};
    end else if (cyc_clr_s) begin
      cyc_cnt_r <= {CYC_CNT_W{1'b0}};
    end else if (enable_r && (cyc_cnt_r != {CYC_CNT_W{1'b1}})) begin
      cyc_cnt_r <= cyc_cnt_r + {{(CYC_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign snapshot_s = {i_pc, i_data, cyc_cnt_r};
`else
  assign snapshot_s = {i_pc, i_data};
`endif

  debug_tx_serializer #(
    .BYTE_SZ (BYTE_SZ),
    .N_BYTES (RPT_BYTES)
  ) u_tx_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (ser_load_s),
    .i_snapshot (snapshot_s),
    .i_start    (ser_start_s),
    .i_tx_done  (ser_tx_done_s),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_busy     (ser_busy_s),
    .o_last     (ser_last_s)
  );

endmodule
